// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the zerocore instruction-fetch front end.
package if_fetch_queue_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Pick the 32-bit instruction out of an aligned 64-bit RAM word.
  function automatic logic [INST_W-1:0] select_word(input logic [DATA_W-1:0] data,
                                                    input logic              hi);
    return hi ? data[DATA_W-1:INST_W] : data[INST_W-1:0];
  endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries; flush beats push/pop.
// When empty the head output keeps the last entry that was at the head.
module if_fetch_queue_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_c;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_o   = (count_q == '0);
  assign full_c    = (count_q == CW'(DEPTH));
  assign do_pop_c  = pop_i & ~empty_o;
  assign do_push_c = push_i & (~full_c | do_pop_c);
  assign head_o    = empty_o ? last_q : mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Shadow the current head so the output never falls back to a stale slot.
      if (!empty_o) last_q <= mem_q[rd_ptr_q];
      if (do_push_c && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues aligned RAM reads, selects the
// 32-bit word and queues {pc, inst} for decode; redirect flushes everything.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              issue_c;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy_c;
  logic              fifo_empty;
  logic              push_c;
  logic              pop_c;
  fetch_entry_t      push_entry_c;
  fetch_entry_t      head;

  // Queued entries plus the outstanding read must fit in the queue.
  assign occupancy_c = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    issue_c    = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        state_d = FETCH;
        issue_c = ~redirect_valid & (occupancy_c < (CNT_W + 1)'(DEPTH));
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_pc & ~ADDR_W'(3);
    end else if (issue_c) begin
      pc_d       = pc_q + ADDR_W'(4);
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign ram_rd_en   = issue_c;
  assign ram_rd_addr = {pc_q[ADDR_W-1:3], 3'b000};

  // A response landing in a redirect cycle belongs to the old stream.
  assign push_c            = inflight_q & ~redirect_valid;
  assign push_entry_c.pc   = req_pc_q;
  assign push_entry_c.inst = select_word(ram_rd_data, req_pc_q[2]);
  assign pop_c             = inst_valid & inst_ready & ~redirect_valid;

  if_fetch_queue_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_data_i (push_entry_c),
    .pop_i       (pop_c),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign inst_valid = ~fifo_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_fetch_queue;

  localparam int DEPTH_M = 4;
  localparam logic [31:0] K = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ram_rd_en;
  logic [63:0] ram_rd_addr;
  logic [63:0] ram_rd_data = 64'h0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  if_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ram_rd_en      (ram_rd_en),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rd_data    (ram_rd_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] ram_fn(input logic [63:0] base);
    if (base == 64'h8000_0000) return 64'h0000_0093_0000_0013;
    return {(base[31:0] + 32'd4) ^ K, base[31:0] ^ K};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] pc);
    logic [63:0] d;
    d = ram_fn({pc[63:3], 3'b000});
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  // Instruction RAM: one-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram_fn(ram_rd_addr);
    else           ram_rd_data <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // Reference model: queue of expected entries plus one pending read.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  logic [63:0] m_ppc;
  bit          m_pend;
  bit          m_fetch;
  bit          m_iss;
  logic [63:0] m_last_pc;
  logic [31:0] m_last_inst;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_pc        = 64'h8000_0000;
      m_ppc       = '0;
      m_pend      = 0;
      m_fetch     = 0;
      m_last_pc   = '0;
      m_last_inst = '0;
    end else begin
      m_iss = m_fetch && !redirect_valid && (mq.size() + int'(m_pend) < DEPTH_M);
      if (mq.size() > 0) begin
        m_last_pc   = mq[0].pc;
        m_last_inst = mq[0].inst;
      end
      if (redirect_valid) begin
        mq.delete();
        m_pend = 0;
        m_pc   = redirect_pc & ~64'h3;
      end else begin
        if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
        if (m_pend) mq.push_back('{m_ppc, exp_inst(m_ppc)});
        if (m_iss) begin
          m_ppc  = m_pc;
          m_pend = 1;
          m_pc   = m_pc + 64'd4;
        end else begin
          m_pend = 0;
        end
      end
      m_fetch = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  bit exp_en;
  always @(negedge clk) begin
    exp_en = m_fetch && !redirect_valid && (mq.size() + int'(m_pend) < DEPTH_M);
    chk("m_rd_en", ram_rd_en, exp_en);
    chk("m_rd_addr", ram_rd_addr, {m_pc[63:3], 3'b000});
    chk("m_valid", inst_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("m_inst_pc", inst_pc, mq[0].pc);
      chk("m_inst", inst, mq[0].inst);
    end else begin
      chk("m_hold_pc", inst_pc, m_last_pc);
      chk("m_hold_inst", inst, m_last_inst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] hd_pc;
  bit          found;

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    repeat (3) tick();
    chk("rst_valid", inst_valid, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);

    // Reset release and first-fetch latency
    rst = 1'b1;
    #1 chk("c0_rd_en", ram_rd_en, 0);
    tick(); #1;
    chk("c1_rd_en", ram_rd_en, 1);
    chk("c1_rd_addr", ram_rd_addr, 64'h8000_0000);
    chk("c1_valid", inst_valid, 0);
    tick(); #1;
    chk("c2_valid", inst_valid, 0);
    tick(); #1;
    chk("c3_valid", inst_valid, 1);
    chk("c3_pc", inst_pc, 64'h8000_0000);
    chk("c3_inst", inst, 32'h0000_0013);
    tick(); #1;
    chk("c4_pc", inst_pc, 64'h8000_0004);
    chk("c4_inst", inst, 32'h0000_0093);
    tick(); #1;
    chk("c5_pc", inst_pc, 64'h8000_0008);
    chk("c5_inst", inst, 32'h40DE_0008);

    // Back-pressure: queue fills, fetch stops, head holds
    inst_ready = 1'b0;
    hd_pc = mq[0].pc;
    repeat (10) tick();
    #1;
    chk("full_rd_en", ram_rd_en, 0);
    chk("full_valid", inst_valid, 1);
    chk("full_head", inst_pc, hd_pc);

    // One pop leaves 3 queued; the next cycle issues so 1 is in flight
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1 chk("refill_rd_en", ram_rd_en, 1);
    tick();
    chk("pre_redir_occ", mq.size() * 10 + int'(m_pend), 31);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    #1 chk("redir_no_issue", ram_rd_en, 0);
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #1;
    chk("redir_empty", inst_valid, 0);
    chk("redir_rd_en", ram_rd_en, 1);
    chk("redir_addr", ram_rd_addr, 64'h8000_0100);
    tick(); #1;
    chk("redir_c2_valid", inst_valid, 0);
    tick(); #1;
    chk("redir_first_valid", inst_valid, 1);
    chk("redir_first_pc", inst_pc, 64'h8000_0100);
    chk("redir_first_inst", inst, 32'h40DE_0100);

    // Redirect coinciding with a pop handshake
    redirect_valid = 1'b1;
    redirect_pc    = 64'h9000_0000;
    tick();
    redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (inst_valid) found = 1;
      else tick();
    end
    chk("pop_redir_seen", found, 1);
    chk("pop_redir_pc", inst_pc, 64'h9000_0000);
    chk("pop_redir_inst", inst, 32'h50DE_0000);

    // Reset in mid-stream with two entries queued
    inst_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (mq.size() == 2) found = 1;
    end
    chk("two_queued", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", inst_valid, 0);
    chk("midrst_rd_en", ram_rd_en, 0);
    tick(); tick();
    rst = 1'b1;
    inst_ready = 1'b1;
    tick(); tick(); tick(); #1;
    chk("restart_valid", inst_valid, 1);
    chk("restart_pc", inst_pc, 64'h8000_0000);
    chk("restart_inst", inst, 32'h0000_0013);

    // Random back-pressure and redirects, including a PC wrap target
    for (int i = 0; i < 600; i++) begin
      tick();
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 4) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF5;
      else                           redirect_pc = {32'h0, $urandom()};
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
